// File: rtl/port_link.sv
// port_link: host-side peripheral on the far end of the CPU's 4-bit
// port_input/port_output pair.
//
// Host-to-CPU bytes go into an RX FIFO. The CPU reads each byte as two nibbles.
// CPU-to-host bytes are built from four 2-bit shifts and then pushed into a
// TX FIFO.
//
// The CPU issues a command by toggling bit 3 of cpu_port_output. Bits 2:0 carry
// the command code.
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous, active-high reset
//   cpu_port_output CPU command nibble {phase, cmd[2:0]}
//   cpu_port_input  registered response nibble back to the CPU
//   host_rx_*       valid/ready byte stream into the RX FIFO
//   host_tx_*       first-word-fall-through byte stream out of the TX FIFO
module port_link #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cpu_port_output,
  output logic [3:0] cpu_port_input,
  input  logic [7:0] host_rx_data,
  input  logic       host_rx_valid,
  output logic       host_rx_ready,
  output logic [7:0] host_tx_data,
  output logic       host_tx_valid,
  input  logic       host_tx_ready
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [7:0]     rx_mem_q [FIFO_DEPTH];
  logic [7:0]     tx_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
  logic [PTR_W-1:0] tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
  logic [PTR_W:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [5:0]     shreg_q, shreg_d;
  logic [1:0]     shcnt_q, shcnt_d;
  logic           err_q, err_d;
  logic           primed_q, primed_d;
  logic           last_phase_q, last_phase_d;
  logic [3:0]     resp_q, resp_d;

  logic       rx_full, rx_empty, rx_push, rx_pop;
  logic       tx_full, tx_push, tx_pop;
  logic       fire;
  logic [2:0] cmd;
  logic [7:0] rx_head, tx_byte;

  assign host_rx_ready  = !rx_full;
  assign host_tx_valid  = (tx_cnt_q != '0);
  assign host_tx_data   = tx_mem_q[tx_rd_q];
  assign cpu_port_input = resp_q;

  always_comb begin
    rx_rd_d      = rx_rd_q;
    rx_wr_d      = rx_wr_q;
    tx_rd_d      = tx_rd_q;
    tx_wr_d      = tx_wr_q;
    rx_cnt_d     = rx_cnt_q;
    tx_cnt_d     = tx_cnt_q;
    shreg_d      = shreg_q;
    shcnt_d      = shcnt_q;
    err_d        = err_q;
    primed_d     = primed_q;
    last_phase_d = last_phase_q;
    resp_d       = resp_q;
    rx_pop       = 1'b0;
    tx_push      = 1'b0;

    cmd      = cpu_port_output[2:0];
    rx_head  = rx_mem_q[rx_rd_q];
    tx_byte  = {shreg_q, cmd[1:0]};
    // Full status is taken before any same-cycle pop, so a full FIFO never
    // accepts a push even while it is being drained.
    rx_full  = (rx_cnt_q == FULL_CNT);
    rx_empty = (rx_cnt_q == '0);
    tx_full  = (tx_cnt_q == FULL_CNT);
    rx_push  = host_rx_valid && !rx_full;
    tx_pop   = (tx_cnt_q != '0) && host_tx_ready;
    fire     = primed_q && (cpu_port_output[3] != last_phase_q);

    // The first edge after reset only records the phase level. This keeps a
    // port level held across reset from being taken as a toggle.
    if (!primed_q) begin
      primed_d     = 1'b1;
      last_phase_d = cpu_port_output[3];
    end else if (fire) begin
      last_phase_d = cpu_port_output[3];
    end

    if (fire) begin
      casez (cmd)
        3'b001, 3'b010: begin
          if (rx_empty) begin
            resp_d = 4'h0;
            err_d  = 1'b1;
          end else if (cmd[1]) begin
            resp_d = rx_head[3:0];
            rx_pop = 1'b1;
          end else begin
            resp_d = rx_head[7:4];
          end
        end
        3'b011: err_d = 1'b0;
        3'b1??: begin
          shreg_d = {shreg_q[3:0], cmd[1:0]};
          shcnt_d = shcnt_q + 2'd1;
          if (shcnt_q == 2'd3) begin
            if (tx_full) err_d = 1'b1;
            else         tx_push = 1'b1;
          end
        end
        default: ;
      endcase
    end

    rx_cnt_d = rx_cnt_q + (PTR_W+1)'(rx_push) - (PTR_W+1)'(rx_pop);
    rx_wr_d  = rx_wr_q + PTR_W'(rx_push);
    rx_rd_d  = rx_rd_q + PTR_W'(rx_pop);
    tx_cnt_d = tx_cnt_q + (PTR_W+1)'(tx_push) - (PTR_W+1)'(tx_pop);
    tx_wr_d  = tx_wr_q + PTR_W'(tx_push);
    tx_rd_d  = tx_rd_q + PTR_W'(tx_pop);

    // STATUS and SHIFT responses report FIFO state after this edge's updates.
    // STATUS reports err as it was before this edge clears it.
    if (fire && cmd == 3'b011)
      resp_d = {err_q, shcnt_q != 2'd0, tx_cnt_d == FULL_CNT, rx_cnt_d != '0};
    else if (fire && cmd[2])
      resp_d = {tx_cnt_d == FULL_CNT, 1'b0, shcnt_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_rd_q      <= '0;
      rx_wr_q      <= '0;
      tx_rd_q      <= '0;
      tx_wr_q      <= '0;
      rx_cnt_q     <= '0;
      tx_cnt_q     <= '0;
      shreg_q      <= '0;
      shcnt_q      <= '0;
      err_q        <= 1'b0;
      primed_q     <= 1'b0;
      last_phase_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      rx_rd_q      <= rx_rd_d;
      rx_wr_q      <= rx_wr_d;
      tx_rd_q      <= tx_rd_d;
      tx_wr_q      <= tx_wr_d;
      rx_cnt_q     <= rx_cnt_d;
      tx_cnt_q     <= tx_cnt_d;
      shreg_q      <= shreg_d;
      shcnt_q      <= shcnt_d;
      err_q        <= err_d;
      primed_q     <= primed_d;
      last_phase_q <= last_phase_d;
      resp_q       <= resp_d;
    end
  end

  // Storage needs no reset. Only entries that sit between the pointers are
  // ever observed.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wr_q] <= host_rx_data;
    if (tx_push) tx_mem_q[tx_wr_q] <= tx_byte;
  end

endmodule

// File: tb/tb_port_link.sv
module tb_port_link;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cpu_port_output;
  logic [3:0] cpu_port_input;
  logic [7:0] host_rx_data;
  logic       host_rx_valid;
  logic       host_rx_ready;
  logic [7:0] host_tx_data;
  logic       host_tx_valid;
  logic       host_tx_ready;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic ph;

  always #5 clk = ~clk;

  port_link #(.FIFO_DEPTH(4), .PTR_W(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_port_output (cpu_port_output),
    .cpu_port_input  (cpu_port_input),
    .host_rx_data    (host_rx_data),
    .host_rx_valid   (host_rx_valid),
    .host_rx_ready   (host_rx_ready),
    .host_tx_data    (host_tx_data),
    .host_tx_valid   (host_tx_valid),
    .host_tx_ready   (host_tx_ready)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Toggle the phase bit with a new command; the response is valid after the sampling edge.
  task automatic cmd(input logic [2:0] c);
    ph = ~ph;
    cpu_port_output = {ph, c};
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    cmd({1'b1, b[7:6]});
    cmd({1'b1, b[5:4]});
    cmd({1'b1, b[3:2]});
    cmd({1'b1, b[1:0]});
  endtask

  task automatic push_rx(input logic [7:0] b);
    host_rx_data  = b;
    host_rx_valid = 1'b1;
    tick();
    host_rx_valid = 1'b0;
  endtask

  logic [7:0] tx_exp [4];
  logic [7:0] rx_exp [4];

  initial begin
    reset           = 1'b1;
    cpu_port_output = 4'b1011;
    ph              = 1'b1;
    host_rx_data    = 8'h00;
    host_rx_valid   = 1'b0;
    host_tx_ready   = 1'b0;
    tick();
    chk("reset_rx_ready", {7'd0, host_rx_ready}, 8'd1);
    chk("reset_tx_valid", {7'd0, host_tx_valid}, 8'd0);
    chk("reset_resp", {4'd0, cpu_port_input}, 8'h0);
    reset = 1'b0;
    tick();
    tick();
    chk("prime_no_cmd", {4'd0, cpu_port_input}, 8'h0);
    cmd(3'b011);
    chk("status_after_prime", {4'd0, cpu_port_input}, 8'h0);

    push_rx(8'hA5);
    cmd(3'b001);
    chk("read_hi_a5", {4'd0, cpu_port_input}, 8'hA);
    tick();
    chk("static_level_hold", {4'd0, cpu_port_input}, 8'hA);
    cmd(3'b010);
    chk("read_lo_a5", {4'd0, cpu_port_input}, 8'h5);
    cmd(3'b011);
    chk("status_rx_empty", {4'd0, cpu_port_input}, 8'h0);

    cmd(3'b110);
    chk("shift1_resp", {4'd0, cpu_port_input}, 8'h1);
    cmd(3'b101);
    chk("shift2_resp", {4'd0, cpu_port_input}, 8'h2);
    cmd(3'b111);
    chk("shift3_resp", {4'd0, cpu_port_input}, 8'h3);
    chk("tx_not_yet", {7'd0, host_tx_valid}, 8'd0);
    cmd(3'b100);
    chk("shift4_resp", {4'd0, cpu_port_input}, 8'h0);
    chk("tx_data_9c", host_tx_data, 8'h9C);
    chk("tx_valid_9c", {7'd0, host_tx_valid}, 8'd1);
    host_tx_ready = 1'b1;
    tick();
    host_tx_ready = 1'b0;
    chk("tx_popped", {7'd0, host_tx_valid}, 8'd0);

    tx_exp[0] = 8'h11; tx_exp[1] = 8'h22; tx_exp[2] = 8'h33; tx_exp[3] = 8'h44;
    for (int i = 0; i < 4; i++) send_byte(tx_exp[i]);
    chk("tx_full_resp", {4'd0, cpu_port_input}, 8'h8);
    send_byte(8'h55);
    chk("tx_drop_resp", {4'd0, cpu_port_input}, 8'h8);
    chk("tx_head_kept", host_tx_data, 8'h11);
    cmd(3'b011);
    chk("status_err_full", {4'd0, cpu_port_input}, 8'hA);
    cmd(3'b011);
    chk("status_err_clr", {4'd0, cpu_port_input}, 8'h2);
    host_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("tx_drain_data", host_tx_data, tx_exp[i]);
      tick();
    end
    host_tx_ready = 1'b0;
    chk("tx_drained", {7'd0, host_tx_valid}, 8'd0);

    push_rx(8'h1A); push_rx(8'h2B); push_rx(8'h3C); push_rx(8'h4D);
    chk("rx_full_ready", {7'd0, host_rx_ready}, 8'd0);
    host_rx_data  = 8'h54;
    host_rx_valid = 1'b1;
    cmd(3'b010);
    chk("rx_full_read_lo", {4'd0, cpu_port_input}, 8'hA);
    chk("rx_ready_after_pop", {7'd0, host_rx_ready}, 8'd1);
    tick();
    host_rx_valid = 1'b0;
    rx_exp[0] = 8'h2B; rx_exp[1] = 8'h3C; rx_exp[2] = 8'h4D; rx_exp[3] = 8'h54;
    for (int i = 0; i < 4; i++) begin
      cmd(3'b001);
      chk("rx_order_hi", {4'd0, cpu_port_input}, {4'd0, rx_exp[i][7:4]});
      cmd(3'b010);
      chk("rx_order_lo", {4'd0, cpu_port_input}, {4'd0, rx_exp[i][3:0]});
    end
    cmd(3'b010);
    chk("read_lo_empty", {4'd0, cpu_port_input}, 8'h0);
    cmd(3'b011);
    chk("status_err_empty", {4'd0, cpu_port_input}, 8'h8);

    push_rx(8'h77);
    cmd(3'b110);
    cmd(3'b101);
    chk("pre_reset_shift", {4'd0, cpu_port_input}, 8'h2);
    cmd(3'b010);
    chk("pre_reset_read", {4'd0, cpu_port_input}, 8'h7);
    push_rx(8'h88);
    reset = 1'b1;
    tick();
    chk("mid_reset_resp", {4'd0, cpu_port_input}, 8'h0);
    chk("mid_reset_rx_ready", {7'd0, host_rx_ready}, 8'd1);
    reset = 1'b0;
    tick();
    tick();
    cmd(3'b011);
    chk("status_after_reset", {4'd0, cpu_port_input}, 8'h0);
    send_byte(8'h9C);
    chk("clean_byte_after_reset", host_tx_data, 8'h9C);

    reset           = 1'b1;
    cpu_port_output = 4'b1001;
    ph              = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    cmd(3'b011);
    chk("no_spurious_read", {4'd0, cpu_port_input}, 8'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
